// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: default geometry and occupancy-width helper shared by reg_pipe.
package reg_pipe_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one valid+data register slice that loads on advance and drops validity on flush.
module reg_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  always_comb begin
    valid_d = flush_i ? 1'b0 : adv_i ? valid_i : valid_q;
    data_d  = adv_i ? data_i : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage bubble-collapsing valid/ready register pipeline with flush.
// Define REG_PIPE_OCC_EN to add the registered occupancy counter and port.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush
`ifdef REG_PIPE_OCC_EN
  ,
  output logic [occ_w(DEPTH)-1:0] occupancy
`endif
);
  logic [DEPTH-1:0] v, adv, v_in;
  logic [WIDTH-1:0] d [DEPTH];
  logic [WIDTH-1:0] d_in [DEPTH];
  // Ready ripples from the output stage back to the input; an empty stage always accepts.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !v[DEPTH-1] || out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) adv[i] = !v[i] || adv[i+1];
  end
  always_comb begin
    v_in = '0;
    v_in[0] = in_valid;
    d_in[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      v_in[i] = v[i-1];
      d_in[i] = d[i-1];
    end
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    reg_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv_i   (adv[g]),
      .flush_i (flush),
      .valid_i (v_in[g]),
      .data_i  (d_in[g]),
      .valid_o (v[g]),
      .data_o  (d[g])
    );
  end
  assign in_ready  = adv[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
`ifdef REG_PIPE_OCC_EN
  localparam int OW = occ_w(DEPTH);
  logic [OW-1:0] occ_q, occ_d;
  logic          in_xfer, out_xfer;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  always_comb begin
    occ_d = flush ? '0 :
            (in_xfer && !out_xfer) ? occ_q + OW'(1) :
            (out_xfer && !in_xfer) ? occ_q - OW'(1) : occ_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end
  assign occupancy = occ_q;
`endif
endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed table-driven bench for reg_pipe (WIDTH=8, DEPTH=3).
module tb_reg_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
`ifdef REG_PIPE_OCC_EN
  logic [1:0] occupancy;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_pipe #(.WIDTH(8), .DEPTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush)
`ifdef REG_PIPE_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       ov;
    logic [7:0] od;
    logic       ir;
    int         occ;
    string      tag;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_occ(input string nm, input int exp);
`ifdef REG_PIPE_OCC_EN
    chk(nm, 32'(occupancy), 32'(exp));
`endif
  endtask

  function automatic void add(input string tag, input logic iv, input logic [7:0] id,
                              input logic ordy, input logic fl, input logic ov,
                              input logic [7:0] od, input logic ir, input int occ);
    tbl.push_back('{iv, id, ordy, fl, ov, od, ir, occ, tag});
  endfunction

  task automatic run_row(input vec_t r);
    in_valid  = r.iv;
    in_data   = r.id;
    out_ready = r.ordy;
    flush     = r.fl;
    #1;
    chk({r.tag, ".out_valid"}, 32'(out_valid), 32'(r.ov));
    if (r.ov) chk({r.tag, ".out_data"}, 32'(out_data), 32'(r.od));
    chk({r.tag, ".in_ready"}, 32'(in_ready), 32'(r.ir));
    chk_occ({r.tag, ".occupancy"}, r.occ);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with live input must leave the pipe empty
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.out_data", 32'(out_data), 0);
    chk("rst.in_ready", 32'(in_ready), 1);
    chk_occ("rst.occupancy", 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    add("st0", 1, 8'h01, 1, 0, 0, 8'h00, 1, 0);
    add("st1", 1, 8'h02, 1, 0, 0, 8'h00, 1, 1);
    add("st2", 1, 8'h03, 1, 0, 0, 8'h00, 1, 2);
    add("st3", 0, 8'h00, 1, 0, 1, 8'h01, 1, 3);
    add("st4", 0, 8'h00, 1, 0, 1, 8'h02, 1, 2);
    add("st5", 0, 8'h00, 1, 0, 1, 8'h03, 1, 1);
    add("st6", 0, 8'h00, 1, 0, 0, 8'h00, 1, 0);
    add("bp0", 1, 8'h10, 0, 0, 0, 8'h00, 1, 0);
    add("bp1", 1, 8'h11, 0, 0, 0, 8'h00, 1, 1);
    add("bp2", 1, 8'h12, 0, 0, 0, 8'h00, 1, 2);
    add("bp3", 1, 8'h13, 0, 0, 1, 8'h10, 0, 3);
    add("bp4", 1, 8'h13, 0, 0, 1, 8'h10, 0, 3);
    add("bp5", 1, 8'h13, 1, 0, 1, 8'h10, 1, 3);
    add("bp6", 0, 8'h00, 1, 0, 1, 8'h11, 1, 3);
    add("bp7", 0, 8'h00, 1, 0, 1, 8'h12, 1, 2);
    add("bp8", 0, 8'h00, 1, 0, 1, 8'h13, 1, 1);
    add("bp9", 0, 8'h00, 1, 0, 0, 8'h00, 1, 0);
    add("sf0", 1, 8'h20, 0, 0, 0, 8'h00, 1, 0);
    add("sf1", 1, 8'h21, 0, 0, 0, 8'h00, 1, 1);
    add("sf2", 1, 8'h22, 0, 0, 0, 8'h00, 1, 2);
    for (int k = 0; k < 5; k++)
      add($sformatf("sm%0d", k), 1, 8'(8'h23 + k), 1, 0, 1, 8'(8'h20 + k), 1, 3);
    for (int k = 0; k < 3; k++)
      add($sformatf("sd%0d", k), 0, 8'h00, 1, 0, 1, 8'(8'h25 + k), 1, 3 - k);
    add("sd3", 0, 8'h00, 1, 0, 0, 8'h00, 1, 0);
    add("fl0", 1, 8'h30, 0, 0, 0, 8'h00, 1, 0);
    add("fl1", 1, 8'h31, 0, 0, 0, 8'h00, 1, 1);
    add("fl2", 1, 8'h55, 0, 1, 0, 8'h00, 1, 2);
    add("fl3", 0, 8'h00, 1, 0, 0, 8'h00, 1, 0);
    add("fl4", 0, 8'h00, 1, 0, 0, 8'h00, 1, 0);
    add("fl5", 0, 8'h00, 1, 0, 0, 8'h00, 1, 0);
    foreach (tbl[i]) run_row(tbl[i]);

    // asynchronous reset between edges while the pipe is full
    out_ready = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'h40 + k);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("ar.pre_valid", 32'(out_valid), 1);
    chk("ar.pre_data", 32'(out_data), 32'h40);
    rst_n = 1'b0;
    #1;
    chk("ar.out_valid", 32'(out_valid), 0);
    chk("ar.out_data", 32'(out_data), 0);
    chk("ar.in_ready", 32'(in_ready), 1);
    chk_occ("ar.occupancy", 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 8'h50;
    tick();
    in_data  = 8'h51;
    tick();
    in_valid = 1'b0;
    chk("rf.early_valid", 32'(out_valid), 0);
    tick();
    chk("rf.first_valid", 32'(out_valid), 1);
    chk("rf.first_data", 32'(out_data), 32'h50);
    tick();
    chk("rf.second_data", 32'(out_data), 32'h51);
    chk_occ("rf.occupancy", 1);
    tick();
    chk("rf.empty", 32'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
- REQ-001: Parameter WIDTH, default 8, data bits per stage; SHALL be >= 1.
- REQ-002: Parameter DEPTH, default 4, number of register stages; SHALL be >= 1.
- REQ-003: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous and active-low.
- REQ-005: in_valid  input  1  upstream data valid.
- REQ-006: in_ready  output  1  pipe can accept this cycle.
- REQ-007: in_data  input  WIDTH  upstream data.
- REQ-008: out_valid  output  1  last stage holds valid data.
- REQ-009: out_ready  input  1  downstream accepts this cycle.
- REQ-010: out_data  output  WIDTH  last-stage data.
- REQ-011: flush  input  1  synchronous discard of all pipe contents.
- REQ-012: occupancy  output  $clog2(DEPTH+1)  count of valid stages (present only with REG_PIPE_OCC_EN).

Function
- REQ-013: Each stage i SHALL hold a data register and a valid bit; out_valid/out_data SHALL be driven directly from stage DEPTH-1 registers.
- REQ-014: Stage DEPTH-1 advances when !valid or out_ready; stage i<DEPTH-1 advances when !valid[i] or stage i+1 advances (combinational ready chain, bubble-collapsing).
- REQ-015: in_ready SHALL equal the stage-0 advance condition; a transfer occurs when in_valid && in_ready.
- REQ-016: On advance, stage i SHALL load data/valid from stage i-1 (stage 0 from in_data/in_valid && in_ready); otherwise it SHALL hold.
- REQ-017: Latency with out_ready held high: data accepted at edge N SHALL appear on out_data with out_valid at edge N+DEPTH-1 (visible after DEPTH edges counting the capturing edge); throughput one word per cycle.
- REQ-018: Data SHALL leave in acceptance order; no word SHALL be dropped or duplicated while out_ready is low.
- REQ-019: Full (all DEPTH valid) with out_ready low: in_ready SHALL be 0; full with out_ready high: in_ready SHALL be 1 and input/output transfers SHALL occur in the same cycle.
- REQ-020: Data registers of non-advancing stages SHALL not change; data of invalid stages is don't-care to consumers but SHALL not be X after reset.
- REQ-021: flush SHALL clear all valid bits at the next edge and take priority over any same-cycle input or output transfer; in_ready SHALL still be reported per REQ-015 but the accepted word is discarded.
- REQ-022: DEPTH=1 SHALL degenerate to a single registered stage with in_ready = !out_valid || out_ready.

Reset
- REQ-023: rst_n low SHALL immediately clear every valid bit and every data register to 0, independent of clk.
- REQ-024: During reset out_valid=0, out_data=0, occupancy=0, in_ready=1.
- REQ-025: Reset asserted mid-transfer SHALL discard all contents; first edge after rst_n rises SHALL behave as an empty pipe.

Configuration
- REQ-026: Macro REG_PIPE_OCC_EN defined: occupancy port and a registered counter exist; counter +1 on input-only transfer, -1 on output-only transfer, unchanged on both or neither, 0 on flush, and SHALL always equal the popcount of valid bits.
- REQ-027: REG_PIPE_OCC_EN undefined: no occupancy port and no counter logic; all other behaviour identical.

Structure
- REQ-028: Package reg_pipe_pkg SHALL hold default WIDTH/DEPTH constants and an occupancy-width function.
- REQ-029: Sub-module reg_pipe_stage (one valid+data register with advance/flush inputs, async active-low reset) SHALL be instantiated DEPTH times via generate.

Verification (WIDTH=8, DEPTH=3, REG_PIPE_OCC_EN defined)
- REQ-030: Reset check: rst_n=0 with in_valid=1, in_data=8'hAA -> out_valid=0, out_data=8'h00, occupancy=0, in_ready=1.
- REQ-031: Streaming: out_ready=1, push 8'h01,8'h02,8'h03 back-to-back -> out_data 01,02,03 on consecutive cycles, 3-cycle latency, occupancy peaks at 3.
- REQ-032: Backpressure: out_ready=0, push 8'h10..8'h13 -> in_ready drops after 3 accepts, occupancy=3; raise out_ready -> 10,11,12,13 in order, none lost.
- REQ-033: Simultaneous: full pipe, out_ready=1, in_valid=1 for 5 cycles -> occupancy stays 3, one word out per cycle.
- REQ-034: Flush: pipe holding 2 words, flush=1 with in_valid=1, in_data=8'h55 -> next cycle out_valid=0, occupancy=0, 8'h55 never emerges.
- REQ-035: Async reset mid-stream: drop rst_n between edges -> outputs clear before next edge; after release pipe refills from empty correctly.
